prog_counter: RTL
=================

Name: prog_counter

Overview:
- Parametrised successor to the lab 4-bit slow counter.
- Integrates a programmable prescaler that issues a single-cycle count-enable tick, so the whole block runs on one clock with no derived clock.
- Adds:
  - configurable width and modulus (limit)
  - up/down direction
  - synchronous parallel load
  - free-running (wrap) or one-shot mode
  - terminal-count pulse and done flag
- Drives LED/7-seg display logic and serves as a generic event timer in later labs.

Parameters:
- WIDTH, 4, counter width in bits.
- DIV, 16777216, prescaler period in mainClock cycles (DIV >= 1). The default matches the 24-bit divider already in use.
- DIV_BITS, 24, prescaler register width; must satisfy 2^DIV_BITS >= DIV.
- RESET_VALUE, all ones (WIDTH bits), count value after reset.

Ports:
- mainClock  in   1         system clock, all logic on rising edge
- reset      in   1         asynchronous, active-low reset
- en         in   1         run enable; 0 freezes prescaler and count
- up         in   1         1 = count up, 0 = count down
- oneshot    in   1         1 = stop at terminal count, 0 = wrap
- limit      in   WIDTH     modulus top value (count range 0..limit)
- load       in   1         synchronous load strobe
- load_val   in   WIDTH     value loaded when load = 1
- count      out  WIDTH     registered counter value
- tick       out  1         registered prescaler tick, high 1 cycle per DIV enabled cycles
- tc         out  1         registered terminal-count pulse, 1 cycle
- done       out  1         registered; high while in HALT state

Behaviour:
- Reset (reset = 0, async): count = RESET_VALUE, prescaler = 0, tick = 0, tc = 0, done = 0, state = RUN. Release is taken on the next rising edge.
- Prescaler:
  - If en = 1 and load = 0, div_cnt increments each cycle.
  - When div_cnt == DIV-1, div_cnt <= 0 and tick <= 1 for exactly one cycle; otherwise tick <= 0.
  - DIV = 1 gives tick high every enabled cycle.
  - en = 0 holds div_cnt and forces tick <= 0.
- Count update uses the registered tick, so count changes 1 cycle after tick is seen high.
- Priority per edge: reset > load > tick-driven count > hold.
- Load:
  - count <= load_val, div_cnt <= 0, tick <= 0, tc <= 0, state <= RUN (done <= 0).
  - Load acts even when en = 0 and in HALT.
- State RUN, on tick = 1:
  - Up: if count >= limit, the counter is at terminal. Otherwise count <= count + 1.
  - Down: if count == 0, the counter is at terminal. Otherwise count <= count - 1.
  - At terminal with oneshot = 0: up wraps to 0, down wraps to limit, tc <= 1.
  - At terminal with oneshot = 1: count holds, tc <= 1, state <= HALT.
- State HALT:
  - Ticks are ignored; count and done = 1 hold.
  - Exit only via load or reset.
  - Prescaler keeps running while en = 1; tick is still visible.
- tc is 0 on every cycle not described above.
- Boundaries:
  - count > limit (after a load or a limit change), up: treated as terminal and wraps to 0 on the next tick.
  - count > limit, down: decrements normally until it reaches 0.
  - limit = 0: count stays 0 and tc pulses on every tick, in either direction.
  - Arithmetic is modulo 2^WIDTH internally. No wrap occurs other than at the terminal cases above.
- Changes to up, oneshot or limit take effect on the next tick. No reset or clearing is needed.
- load and tick on the same edge: load wins and the tick is discarded.
- Reset asserted mid-count or in HALT: immediately returns to the reset values.

Test Plan (WIDTH = 4, DIV = 4, RESET_VALUE = 4'hF):
- Reset release, en = 1, up = 1, limit = 15, oneshot = 0.
  - tick every 4th cycle.
  - First tick: count 15 -> 0 with tc = 1.
  - Then 1, 2, ... 15, 0, with tc pulsing once per 16 ticks.
- limit = 9, up = 1.
  - Count runs 0..9 -> 0, tc on the 9 -> 0 tick.
  - Switch up = 0 at count = 3: sequence 2, 1, 0, 9, with tc on the 0 -> 9 tick.
- oneshot = 1, up = 1, limit = 5, load 4'd3.
  - Sequence 4, 5; next tick: count stays 5, tc = 1 for 1 cycle, done = 1.
  - Further ticks produce no change.
  - load 4'd0: done = 0, counting resumes.
- en = 0 for 10 cycles mid-run: count and div_cnt frozen, tick = 0. Resume with en = 1: next tick exactly DIV - elapsed cycles later.
- load = 1 on the same edge as tick, load_val = 4'd7: count = 7 (no increment applied); next tick 4 cycles later gives 8.
- limit = 0: count 0 and tc = 1 every tick. Assert reset mid-run: count = 15, done = 0, tc = 0 immediately (asynchronous, before the next clock edge).

Source files
------------

// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with an integrated prescaler tick,
// optional one-shot halt, synchronous load, terminal-count pulse and done flag.
module prog_counter #(
  parameter int                 WIDTH       = 4,
  parameter int                 DIV         = 16777216,
  parameter int                 DIV_BITS    = 24,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '1
) (
  input  logic             mainClock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             done
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(DIV - 1);
  localparam logic [DIV_BITS-1:0] DIV_ONE  = DIV_BITS'(1);
  localparam logic [WIDTH-1:0]    CNT_ONE  = WIDTH'(1);

  state_t              state;
  logic [DIV_BITS-1:0] div_cnt;
  logic                at_terminal;

  // Count above limit while counting up is treated as terminal so it wraps to 0.
  always_comb begin
    at_terminal = 1'b0;
    if (up) at_terminal = (count >= limit);
    else    at_terminal = (count == '0);
  end

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
      count   <= RESET_VALUE;
      tc      <= 1'b0;
      done    <= 1'b0;
      state   <= RUN;
    end else if (load) begin
      // A tick pending on this edge is discarded along with the prescaler phase.
      div_cnt <= '0;
      tick    <= 1'b0;
      count   <= load_val;
      tc      <= 1'b0;
      done    <= 1'b0;
      state   <= RUN;
    end else begin
      if (en) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          tick    <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_ONE;
          tick    <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      tc <= 1'b0;
      if (tick && state == RUN) begin
        if (at_terminal) begin
          tc <= 1'b1;
          if (oneshot) begin
            state <= HALT;
            done  <= 1'b1;
          end else begin
            count <= up ? '0 : limit;
          end
        end else begin
          count <= up ? count + CNT_ONE : count - CNT_ONE;
        end
      end
    end
  end

endmodule
